// File: rtl/key_mode_encoder_if.sv
// Pushbutton-to-mode interface: raw keys in, latched one-hot mode, restart strobe and levels out.
// Ports: inpulse (4, raw active-low keys), out (4, one-hot mode or 0000),
//        mode_stb (1, one-cycle reload pulse), key_level (4, debounced active-high levels).
interface key_mode_encoder_if;
  logic [3:0] inpulse;
  logic [3:0] out;
  logic       mode_stb;
  logic [3:0] key_level;

  // master: the board/bench side that owns the buttons and watches the mode
  modport master (
    output inpulse,
    input  out,
    input  mode_stb,
    input  key_level
  );

  // slave: the encoder itself
  modport slave (
    input  inpulse,
    output out,
    output mode_stb,
    output key_level
  );
endinterface

// File: rtl/key_mode_encoder.sv
// Debounces 4 raw active-low pushbuttons and encodes presses into a latched one-hot mode word.
// Latency: mode/strobe update DEB_CYCLES+3 clk edges after the first edge that samples a key low.
// No backpressure: a one-cycle mode_stb accompanies every accepted press; the consumer must take it.
// Ports: clk, rst (async active-high), kif (slave modport: inpulse in; out, mode_stb, key_level out).
module key_mode_encoder #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic                clk,
  input  logic                rst,
  key_mode_encoder_if.slave   kif
);

  typedef enum logic [1:0] {
    REL  = 2'd0,
    PCHK = 2'd1,
    PRS  = 2'd2,
    RCHK = 2'd3
  } key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-flop synchroniser; resets to the released (high) level so reset
  // never looks like a press.
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= kif.inpulse;
      sync2 <= sync1;
    end
  end

  assign k = ~sync2;

  logic [3:0] pe;
  logic [3:0] key_lvl;

  // Independent debounce FSM per key. The counter restarts on every state
  // entry and stops at DEB_CYCLES-1, so it can never wrap.
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_evt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= REL;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      case (state_q)
        REL: begin
          if (k[g]) begin
            state_d = PCHK;
            cnt_d   = '0;
          end
        end
        PCHK: begin
          if (!k[g]) begin
            state_d = REL;             // glitch: drop silently
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = PRS;
            cnt_d     = '0;
            press_evt = 1'b1;          // the single event for this press
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRS: begin
          if (!k[g]) begin
            state_d = RCHK;
            cnt_d   = '0;
          end
        end
        RCHK: begin
          if (k[g]) begin
            state_d = PRS;             // release bounce: still held, no new event
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = REL;
          cnt_d   = '0;
        end
      endcase
    end

    assign pe[g]      = press_evt;
    assign key_lvl[g] = (state_q == PRS) || (state_q == RCHK);
  end

  // Lowest-index press wins when several land on the same edge; the rest
  // are discarded rather than queued.
  logic [3:0] win;
  assign win = pe & (~pe + 4'd1);

  logic [3:0] out_q;
  logic       stb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 4'b0000;
      stb_q <= 1'b0;
    end else if (|pe) begin
      // Pressing the already-selected key toggles the driver to stop.
      out_q <= (out_q == win) ? 4'b0000 : win;
      stb_q <= 1'b1;
    end else begin
      stb_q <= 1'b0;
    end
  end

  assign kif.out       = out_q;
  assign kif.mode_stb  = stb_q;
  assign kif.key_level = key_lvl;

endmodule

// File: tb/tb_key_mode_encoder.sv
module tb_key_mode_encoder;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  key_mode_encoder_if tif();

  key_mode_encoder #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .kif (tif)
  );

  always #5 clk = ~clk;

  // Reference model: a key's debounced level flips once the synchronised
  // key value has disagreed with it on DEB+1 consecutive edges; a flip to
  // pressed is a press event. Mode follows the lowest-index event.
  logic [3:0] m_s1, m_s2, m_level, m_out;
  logic       m_stb;
  int         m_run [4];

  always @(posedge clk or posedge rst) begin
    logic [3:0] kk;
    logic [3:0] ev;
    if (rst) begin
      m_s1 = 4'b1111; m_s2 = 4'b1111; m_level = 4'b0000;
      m_out = 4'b0000; m_stb = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      kk   = ~m_s2;
      m_s2 = m_s1;
      m_s1 = tif.inpulse;
      ev   = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (kk[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB + 1) begin
            m_level[i] = kk[i];
            m_run[i]   = 0;
            ev[i]      = kk[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && !m_stb) begin
          m_stb = 1'b1;
          m_out = (m_out == (4'b0001 << i)) ? 4'b0000 : (4'b0001 << i);
        end
      end
    end
  end

  task automatic test_reset();
    tif.inpulse = 4'b1111;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tif.inpulse = 4'b1110;
    repeat (8) @(negedge clk);
    total++;
    if (tif.out !== 4'b0001) begin bad++; $display("FAIL reset_pre_out: got %b want 0001", tif.out); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (tif.out !== 4'b0000) begin bad++; $display("FAIL reset_out: got %b want 0000", tif.out); end
    total++;
    if (tif.mode_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", tif.mode_stb); end
    total++;
    if (tif.key_level !== 4'b0000) begin bad++; $display("FAIL reset_level: got %b want 0000", tif.key_level); end
    @(negedge clk);
    rst = 1'b0;
    // key 0 still low after reset but only for 4 edges: too short
    repeat (4) @(negedge clk);
    tif.inpulse = 4'b1111;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      total++;
      if (tif.mode_stb !== 1'b0 || tif.out !== 4'b0000) begin
        bad++; $display("FAIL reset_short_press: stb=%b out=%b want 0/0000", tif.mode_stb, tif.out);
      end
    end
  endtask

  task automatic test_clean_press();
    tif.inpulse = 4'b1101;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      total++;
      if (tif.mode_stb !== (e == 7)) begin bad++; $display("FAIL press_stb e%0d: got %b want %b", e, tif.mode_stb, e == 7); end
      total++;
      if (tif.key_level !== ((e >= 7) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL press_level e%0d: got %b", e, tif.key_level);
      end
      if (e >= 7) begin
        total++;
        if (tif.out !== 4'b0010) begin bad++; $display("FAIL press_out e%0d: got %b want 0010", e, tif.out); end
      end
    end
    tif.inpulse = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      total++;
      if (tif.key_level[1] !== (e < 7)) begin bad++; $display("FAIL release_level e%0d: got %b want %b", e, tif.key_level[1], e < 7); end
      total++;
      if (tif.out !== 4'b0010 || tif.mode_stb !== 1'b0) begin
        bad++; $display("FAIL release_hold e%0d: out=%b stb=%b want 0010/0", e, tif.out, tif.mode_stb);
      end
    end
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 3; g++) begin
      for (int e = 0; e < 6; e++) begin
        tif.inpulse = (e < 3) ? 4'b1110 : 4'b1111;
        @(negedge clk);
        total++;
        if (tif.mode_stb !== 1'b0 || tif.out !== 4'b0010) begin
          bad++; $display("FAIL glitch: stb=%b out=%b want 0/0010", tif.mode_stb, tif.out);
        end
      end
    end
    repeat (4) @(negedge clk);
    tif.inpulse = 4'b1110;
    repeat (8) @(negedge clk);
    total++;
    if (tif.out !== 4'b0001) begin bad++; $display("FAIL bounce_press_out: got %b want 0001", tif.out); end
    // release with a bounce back to low while the release is being checked
    for (int e = 1; e <= 18; e++) begin
      tif.inpulse = (e > 3 && e <= 6) ? 4'b1110 : 4'b1111;
      @(negedge clk);
      total++;
      if (tif.mode_stb !== 1'b0 || tif.out !== 4'b0001) begin
        bad++; $display("FAIL bounce e%0d: stb=%b out=%b want 0/0001", e, tif.mode_stb, tif.out);
      end
      if (e == 6) begin
        total++;
        if (tif.key_level !== 4'b0001) begin bad++; $display("FAIL bounce_level: got %b want 0001", tif.key_level); end
      end
    end
    total++;
    if (tif.key_level !== 4'b0000) begin bad++; $display("FAIL bounce_final_level: got %b want 0000", tif.key_level); end
  endtask

  task automatic test_toggle();
    logic [3:0] keys [3];
    logic [3:0] want [3];
    keys[0] = 4'b1011; want[0] = 4'b0100;
    keys[1] = 4'b1011; want[1] = 4'b0000;
    keys[2] = 4'b0111; want[2] = 4'b1000;
    for (int p = 0; p < 3; p++) begin
      tif.inpulse = keys[p];
      for (int e = 1; e <= 8; e++) begin
        @(negedge clk);
        total++;
        if (tif.mode_stb !== (e == 7)) begin bad++; $display("FAIL toggle%0d_stb e%0d: got %b", p, e, tif.mode_stb); end
      end
      total++;
      if (tif.out !== want[p]) begin bad++; $display("FAIL toggle%0d_out: got %b want %b", p, tif.out, want[p]); end
      tif.inpulse = 4'b1111;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    tif.inpulse = 4'b0101;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (tif.mode_stb === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL simul_pulses: got %0d want 1", pulses); end
    total++;
    if (tif.out !== 4'b0010) begin bad++; $display("FAIL simul_out: got %b want 0010", tif.out); end
    total++;
    if (tif.key_level !== 4'b1010) begin bad++; $display("FAIL simul_level: got %b want 1010", tif.key_level); end
    tif.inpulse = 4'b1111;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    tif.inpulse = 4'b1110;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tif.mode_stb !== 1'b0 || tif.out !== 4'b0000) begin
      bad++; $display("FAIL midrst: stb=%b out=%b want 0/0000", tif.mode_stb, tif.out);
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      total++;
      if (tif.mode_stb !== (e == 7)) begin bad++; $display("FAIL midrst_stb e%0d: got %b want %b", e, tif.mode_stb, e == 7); end
    end
    total++;
    if (tif.out !== 4'b0001) begin bad++; $display("FAIL midrst_out: got %b want 0001", tif.out); end
    tif.inpulse = 4'b1111;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random_vs_model();
    for (int s = 0; s < 200; s++) begin
      int len;
      if ($urandom_range(0, 3) == 0) tif.inpulse = 4'b1111;
      else tif.inpulse = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        total++;
        if (tif.out !== m_out || tif.mode_stb !== m_stb || tif.key_level !== m_level) begin
          bad++;
          $display("FAIL random seg%0d: out=%b stb=%b lvl=%b want %b %b %b",
                   s, tif.out, tif.mode_stb, tif.key_level, m_out, m_stb, m_level);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.inpulse = 4'b1111;
    test_reset();
    test_clean_press();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random_vs_model();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
